// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
// Multi-cycle fetch/decode/execute controller for the MiniMicro CPU.
// Fetches 32-bit instructions over a req/valid handshake, holds them in an
// instruction register and splits them into fields. It dispatches ALU ops with
// a start/done handshake, and issues write-back, pc update, jumps and halt.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   i_run          level enable for the sequencer
//   o_imem_req     fetch request, held high until accepted
//   o_imem_addr    fetch address (= pc)
//   i_imem_valid   instruction data valid (sampled only in FETCH)
//   i_imem_rdata   instruction word
//   o_opcode       IR[31:27]
//   o_destination  IR[26:18]
//   o_source_1     IR[17:9]
//   o_source_2     IR[8:0]
//   o_alu_start    one-cycle pulse launching an ALU op
//   i_alu_done     ALU result ready (sampled only in WAIT_ALU)
//   o_rf_we        one-cycle register-file write enable
//   o_rf_waddr     register-file write address (= destination)
//   o_pc           current program counter
//   o_busy         high in every state except IDLE and HALT
//   o_halted       high in HALT
//   o_illegal      one-cycle pulse on a reserved opcode
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int PC_WIDTH          = 8,
    parameter int INSTRUCTION_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_run,
    output logic                         o_imem_req,
    output logic [PC_WIDTH-1:0]          o_imem_addr,
    input  logic                         i_imem_valid,
    input  logic [INSTRUCTION_WIDTH-1:0] i_imem_rdata,
    output logic [4:0]                   o_opcode,
    output logic [8:0]                   o_destination,
    output logic [8:0]                   o_source_1,
    output logic [8:0]                   o_source_2,
    output logic                         o_alu_start,
    input  logic                         i_alu_done,
    output logic                         o_rf_we,
    output logic [8:0]                   o_rf_waddr,
    output logic [PC_WIDTH-1:0]          o_pc,
    output logic                         o_busy,
    output logic                         o_halted,
    output logic                         o_illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WAIT_ALU,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [4:0] OP_JMP  = 5'd30;
    localparam logic [4:0] OP_HALT = 5'd31;

    state_t                         r_state;
    state_t                         w_state_next;
    logic [PC_WIDTH-1:0]            r_pc;
    logic [PC_WIDTH-1:0]            w_pc_next;
    logic [INSTRUCTION_WIDTH-1:0]   r_ir;
    logic [INSTRUCTION_WIDTH-1:0]   w_ir_next;

    logic [4:0]                     w_op;
    logic                           w_is_alu;
    logic                           w_is_reserved;
    logic [PC_WIDTH-1:0]            w_pc_inc;
    logic [PC_WIDTH-1:0]            w_jmp_target;
    state_t                         w_retire_state;

    // Field outputs come straight from IR so they stay stable DECODE..WB.
    assign w_op          = r_ir[31:27];
    assign o_opcode      = r_ir[31:27];
    assign o_destination = r_ir[26:18];
    assign o_source_1    = r_ir[17:9];
    assign o_source_2    = r_ir[8:0];
    assign o_rf_waddr    = r_ir[26:18];
    assign o_pc          = r_pc;
    assign o_imem_addr   = r_pc;

    assign w_is_alu      = (w_op >= 5'd1)  && (w_op <= 5'd19);
    assign w_is_reserved = (w_op >= 5'd20) && (w_op <= 5'd29);
    // Natural overflow gives the silent wrap from 2^PC_WIDTH-1 to 0.
    assign w_pc_inc      = r_pc + PC_WIDTH'(1);
    // Jump target is the low PC_WIDTH bits of the source_2 field.
    assign w_jmp_target  = r_ir[PC_WIDTH-1:0];
    // run is sampled in the retiring cycle to choose between FETCH and IDLE.
    assign w_retire_state = i_run ? S_FETCH : S_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_ir    <= w_ir_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_ir_next    = r_ir;
        o_imem_req   = 1'b0;
        o_alu_start  = 1'b0;
        o_rf_we      = 1'b0;
        o_illegal    = 1'b0;
        o_busy       = 1'b1;
        o_halted     = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_run) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                o_imem_req = 1'b1;
                if (i_imem_valid) begin
                    w_ir_next    = i_imem_rdata;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_is_alu) begin
                    w_state_next = S_EXEC;
                end else if (w_op == OP_HALT) begin
                    w_state_next = S_HALT;
                end else begin
                    // NOP, JMP and reserved opcodes all retire from here.
                    w_pc_next    = (w_op == OP_JMP) ? w_jmp_target : w_pc_inc;
                    o_illegal    = w_is_reserved;
                    w_state_next = w_retire_state;
                end
            end
            S_EXEC: begin
                o_alu_start  = 1'b1;
                w_state_next = S_WAIT_ALU;
            end
            S_WAIT_ALU: begin
                if (i_alu_done) begin
                    w_state_next = S_WB;
                end
            end
            S_WB: begin
                o_rf_we      = 1'b1;
                w_pc_next    = w_pc_inc;
                w_state_next = w_retire_state;
            end
            S_HALT: begin
                o_busy   = 1'b0;
                o_halted = 1'b1;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
// Directed testbench for instr_sequencer: a small program memory and ALU
// responder with programmable latencies drive the handshakes, and a monitor
// counts pulses and logs fetch addresses for comparison against hand-computed
// expectations.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

    localparam int PC_WIDTH = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                i_run = 1'b0;
    logic                o_imem_req;
    logic [PC_WIDTH-1:0] o_imem_addr;
    logic                i_imem_valid = 1'b0;
    logic [31:0]         i_imem_rdata = '0;
    logic [4:0]          o_opcode;
    logic [8:0]          o_destination;
    logic [8:0]          o_source_1;
    logic [8:0]          o_source_2;
    logic                o_alu_start;
    logic                i_alu_done = 1'b0;
    logic                o_rf_we;
    logic [8:0]          o_rf_waddr;
    logic [PC_WIDTH-1:0] o_pc;
    logic                o_busy;
    logic                o_halted;
    logic                o_illegal;

    instr_sequencer #(.PC_WIDTH(PC_WIDTH), .INSTRUCTION_WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_run         (i_run),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_valid  (i_imem_valid),
        .i_imem_rdata  (i_imem_rdata),
        .o_opcode      (o_opcode),
        .o_destination (o_destination),
        .o_source_1    (o_source_1),
        .o_source_2    (o_source_2),
        .o_alu_start   (o_alu_start),
        .i_alu_done    (i_alu_done),
        .o_rf_we       (o_rf_we),
        .o_rf_waddr    (o_rf_waddr),
        .o_pc          (o_pc),
        .o_busy        (o_busy),
        .o_halted      (o_halted),
        .o_illegal     (o_illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // program memory and responder state
    logic [31:0] mem [256];
    int mem_delay;
    int alu_delay;
    int mcnt;
    int acnt;
    bit alu_wait;

    // monitor state
    int cyc;
    int n_start, n_we, n_ill, n_req, n_addr_moves;
    int start_cyc, we_cyc, ill_cyc;
    logic [8:0] we_addr;
    bit prev_req;
    logic [PC_WIDTH-1:0] prev_addr;
    logic [PC_WIDTH-1:0] fetch_log [$];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, act, exp);
        end else begin
            $display("ok   %s value=0x%0h", tag, act);
        end
    endtask

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [8:0] d,
                                        input logic [8:0] s1, input logic [8:0] s2);
        return {op, d, s1, s2};
    endfunction

    function automatic logic [63:0] all_outs();
        return {1'b0, o_imem_req, o_imem_addr, o_opcode, o_destination, o_source_1,
                o_source_2, o_alu_start, o_rf_we, o_rf_waddr, o_pc, o_busy, o_halted,
                o_illegal};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = enc(5'd31, 9'd0, 9'd0, 9'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_run = 1'b0;
        i_imem_valid = 1'b0;
        i_imem_rdata = '0;
        i_alu_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0; n_start = 0; n_we = 0; n_ill = 0; n_req = 0; n_addr_moves = 0;
        start_cyc = 0; we_cyc = 0; ill_cyc = 0; we_addr = '0;
        prev_req = 1'b0; prev_addr = '0;
        mcnt = 0; acnt = 0; alu_wait = 1'b0;
        fetch_log.delete();
    endtask

    // One clock: sample outputs just after the edge, then drive responses.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (o_alu_start) begin
            n_start++;
            if (start_cyc == 0) start_cyc = cyc;
        end
        if (o_rf_we) begin
            n_we++;
            we_cyc = cyc;
            we_addr = o_rf_waddr;
        end
        if (o_illegal) begin
            n_ill++;
            ill_cyc = cyc;
        end
        if (o_imem_req) begin
            n_req++;
            if (!prev_req) fetch_log.push_back(o_imem_addr);
            else if (o_imem_addr != prev_addr) n_addr_moves++;
        end
        prev_req = o_imem_req;
        prev_addr = o_imem_addr;
        // memory responder
        if (o_imem_req) begin
            if (mcnt == mem_delay) begin
                i_imem_valid = 1'b1;
                i_imem_rdata = mem[o_imem_addr];
            end else begin
                i_imem_valid = 1'b0;
            end
            mcnt++;
        end else begin
            i_imem_valid = 1'b0;
            mcnt = 0;
        end
        // ALU responder: first sample after alu_start is the first WAIT_ALU cycle
        if (alu_wait) begin
            if (acnt == alu_delay) begin
                i_alu_done = 1'b1;
                alu_wait = 1'b0;
            end else begin
                i_alu_done = 1'b0;
                acnt++;
            end
        end else if (o_alu_start) begin
            alu_wait = 1'b1;
            acnt = 0;
            i_alu_done = 1'b0;
        end else begin
            i_alu_done = 1'b0;
        end
    endtask

    initial begin
        mem_delay = 0;
        alu_delay = 0;
        clear_mem();

        // ---- idle with run low
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq($sformatf("idle_outs_c%0d", i), all_outs(), 64'd0);
        end
        check_eq("idle_req_count", n_req, 0);

        // ---- ALU then HALT, zero wait
        clear_mem();
        mem[0] = enc(5'd3, 9'd5, 9'd1, 9'd2);
        mem[1] = enc(5'd31, 9'd0, 9'd0, 9'd0);
        mem_delay = 0; alu_delay = 0;
        do_reset();
        i_run = 1'b1;
        tick(); tick();
        check_eq("alu_fields", {o_opcode, o_destination, o_source_1, o_source_2},
                 {5'd3, 9'd5, 9'd1, 9'd2});
        repeat (10) tick();
        check_eq("alu_start_cycle", start_cyc, 3);
        check_eq("rf_we_cycle", we_cyc, 5);
        check_eq("rf_waddr", we_addr, 9'd5);
        check_eq("alu_start_count", n_start, 1);
        check_eq("rf_we_count", n_we, 1);
        check_eq("halt_state", {o_halted, o_busy, o_pc}, {1'b1, 1'b0, 8'd1});
        check_eq("halt_opcode", o_opcode, 5'd31);
        repeat (5) tick();
        check_eq("halt_absorbing", {o_halted, o_pc, 1'b0}, {1'b1, 8'd1, 1'b0});

        // ---- same program with memory and ALU wait states
        mem_delay = 3; alu_delay = 4;
        do_reset();
        i_run = 1'b1;
        repeat (40) tick();
        check_eq("slow_req_cycles", n_req, 8);
        check_eq("slow_addr_stable", n_addr_moves, 0);
        check_eq("slow_fetch_count", fetch_log.size(), 2);
        check_eq("slow_alu_start_count", n_start, 1);
        check_eq("slow_rf_we_count", n_we, 1);
        check_eq("slow_halted", {o_halted, o_pc}, {1'b1, 8'd1});

        // ---- jumps and pc wrap
        clear_mem();
        mem[8'h00] = enc(5'd30, 9'd0, 9'd0, 9'h0FE);
        mem[8'hFE] = enc(5'd30, 9'd0, 9'd0, 9'h00F);
        mem[8'h0F] = enc(5'd30, 9'd0, 9'd0, 9'h1FF);
        mem[8'hFF] = enc(5'd0, 9'd0, 9'd0, 9'd0);
        mem_delay = 0; alu_delay = 0;
        do_reset();
        i_run = 1'b1;
        repeat (10) tick();
        i_run = 1'b0;
        repeat (4) tick();
        check_eq("jmp_fetch_count", fetch_log.size(), 5);
        if (fetch_log.size() == 5) begin
            check_eq("jmp_fetch0", fetch_log[0], 8'h00);
            check_eq("jmp_fetch1", fetch_log[1], 8'hFE);
            check_eq("jmp_fetch2", fetch_log[2], 8'h0F);
            check_eq("jmp_fetch3", fetch_log[3], 8'hFF);
            check_eq("wrap_fetch4", fetch_log[4], 8'h00);
        end
        check_eq("jmp_idle", {o_busy, o_halted, o_pc}, {1'b0, 1'b0, 8'hFE});
        check_eq("jmp_no_alu", {n_start[7:0], n_we[7:0]}, 16'd0);

        // ---- reserved opcode
        clear_mem();
        mem[0] = enc(5'd25, 9'd7, 9'd3, 9'd4);
        mem[1] = enc(5'd31, 9'd0, 9'd0, 9'd0);
        do_reset();
        i_run = 1'b1;
        repeat (8) tick();
        check_eq("illegal_pulses", n_ill, 1);
        check_eq("illegal_cycle", ill_cyc, 2);
        check_eq("illegal_no_start", n_start, 0);
        check_eq("illegal_no_we", n_we, 0);
        check_eq("illegal_pc", {o_halted, o_pc}, {1'b1, 8'd1});

        // ---- run dropped during WAIT_ALU
        clear_mem();
        mem[0] = enc(5'd7, 9'd12, 9'd1, 9'd1);
        alu_delay = 3;
        do_reset();
        i_run = 1'b1;
        repeat (4) tick();
        i_run = 1'b0;
        repeat (10) tick();
        check_eq("drop_run_we", n_we, 1);
        check_eq("drop_run_waddr", we_addr, 9'd12);
        check_eq("drop_run_idle", {o_busy, o_halted, o_pc}, {1'b0, 1'b0, 8'd1});
        check_eq("drop_run_fetches", fetch_log.size(), 1);

        // ---- reset asserted during WAIT_ALU
        alu_delay = 5;
        do_reset();
        i_run = 1'b1;
        repeat (4) tick();
        check_eq("pre_reset_busy", o_busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_outs", all_outs(), 64'd0);
        repeat (6) tick();
        check_eq("reset_no_we", n_we, 0);
        check_eq("reset_held_outs", all_outs(), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
